// File: rtl/ysyx_22040759_ifu_ctrl_pkg.sv
// ysyx_22040759_ifu_ctrl_pkg: shared state encodings and defaults for the fetch sequencer
package ysyx_22040759_ifu_ctrl_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int INST_W = 32;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_STOP = 3'd4
    } state_e;
endpackage

// File: rtl/ysyx_22040759_perf_cnt.sv
// ysyx_22040759_perf_cnt: 64-bit wrapping event counter with enable and sync reset
module ysyx_22040759_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [63:0] cnt_o
);
    logic [63:0] cnt_q;
    // count one per enabled cycle, wrapping naturally at 2^64
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 64'd1;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/ysyx_22040759_ifu_ctrl.sv
// ysyx_22040759_ifu_ctrl: single-outstanding instruction fetch sequencer; IFU_PERF_EN adds perf counters
module ysyx_22040759_ifu_ctrl
    import ysyx_22040759_ifu_ctrl_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              imem_resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              fetch_fault,
`ifdef IFU_PERF_EN
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_wait_cnt,
`endif
    output logic              stopped
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, req_addr_q, req_addr_d, inst_pc_q, inst_pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              kill_q, kill_d, inst_valid_q, inst_valid_d, fault_q, fault_d;
    logic              redir, bad;

    assign redir = redirect_valid && (state_q != ST_STOP);
    assign bad   = redirect_pc[1:0] != 2'b00;

    // next-state: redirect outranks everything; kill marks the one in-flight response to drop
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        kill_d       = kill_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        if (redir && bad) begin
            fault_d      = 1'b1;
            inst_valid_d = 1'b0;
            state_d      = ST_STOP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redir) begin
                        pc_d       = redirect_pc;
                        req_addr_d = redirect_pc;
                        state_d    = ST_REQ;
                    end else begin
                        req_addr_d = pc_q;
                        state_d    = halt ? ST_STOP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (redir) begin
                        pc_d   = redirect_pc;
                        kill_d = 1'b1;
                    end
                    if (imem_req_ready) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (redir) begin
                        pc_d = redirect_pc;
                        if (imem_resp_valid) begin
                            kill_d     = 1'b0;
                            req_addr_d = redirect_pc;
                            state_d    = ST_REQ;
                        end else begin
                            kill_d = 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (kill_q) begin
                            kill_d     = 1'b0;
                            req_addr_d = pc_q;
                            state_d    = halt ? ST_STOP : ST_REQ;
                        end else if (imem_resp_err) begin
                            fault_d = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            inst_d       = imem_resp_data;
                            inst_pc_d    = req_addr_q;
                            inst_valid_d = 1'b1;
                            pc_d         = pc_q + ADDR_W'(4);
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redir) begin
                        pc_d         = redirect_pc;
                        req_addr_d   = redirect_pc;
                        inst_valid_d = 1'b0;
                        state_d      = ST_REQ;
                    end else if (inst_ready) begin
                        inst_valid_d = 1'b0;
                        req_addr_d   = pc_q;
                        state_d      = halt ? ST_STOP : ST_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // state and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            kill_q       <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            kill_q       <= kill_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_req_valid = state_q == ST_REQ;
    assign imem_req_addr  = req_addr_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_fault    = fault_q;
    assign stopped        = state_q == ST_STOP;

`ifdef IFU_PERF_EN
    ysyx_22040759_perf_cnt u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (inst_valid_q && inst_ready),
        .cnt_o (perf_fetch_cnt)
    );
    ysyx_22040759_perf_cnt u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_WAIT),
        .cnt_o (perf_wait_cnt)
    );
`endif
endmodule

// File: tb/tb_ysyx_22040759_ifu_ctrl.sv
// tb_ysyx_22040759_ifu_ctrl: directed cycle-by-cycle vectors for the fetch sequencer
module tb_ysyx_22040759_ifu_ctrl;
    logic        clk = 1'b0;
    logic        rst, imem_req_ready, imem_resp_valid, imem_resp_err, inst_ready;
    logic        redirect_valid, halt;
    logic [31:0] imem_resp_data, redirect_pc;
    logic        imem_req_valid, inst_valid, fetch_fault, stopped;
    logic [31:0] imem_req_addr, inst, inst_pc;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt, perf_wait_cnt;
`endif
    int checks = 0;
    int errors = 0;
    int row = 0;

    always #5 clk = ~clk;

    ysyx_22040759_ifu_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .fetch_fault     (fetch_fault),
`ifdef IFU_PERF_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_wait_cnt   (perf_wait_cnt),
`endif
        .stopped         (stopped)
    );

    // inputs driven for the coming edge; expected outputs are those seen before that edge
    typedef struct packed {
        logic [5:0]  in;
        logic [31:0] rdata;
        logic        dv;
        logic [31:0] dpc;
        logic [4:0]  ex;
        logic [31:0] ea;
        logic [31:0] ei;
        logic [31:0] ep;
    } vec_t;

    // in = {rst, req_ready, resp_valid, resp_err, inst_ready, halt}; ex = {check_addr, req_valid, inst_valid, fault, stopped}
    function automatic vec_t mk(input logic [5:0] in, input logic [31:0] rdata, input logic dv,
                                input logic [31:0] dpc, input logic [4:0] ex, input logic [31:0] ea,
                                input logic [31:0] ei, input logic [31:0] ep);
        mk = '{in: in, rdata: rdata, dv: dv, dpc: dpc, ex: ex, ea: ea, ei: ei, ep: ep};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic step(input vec_t x);
        @(negedge clk);
        chk("req_valid", 32'(imem_req_valid), 32'(x.ex[3]));
        chk("inst_valid", 32'(inst_valid), 32'(x.ex[2]));
        chk("fetch_fault", 32'(fetch_fault), 32'(x.ex[1]));
        chk("stopped", 32'(stopped), 32'(x.ex[0]));
        if (x.ex[4]) chk("req_addr", imem_req_addr, x.ea);
        if (x.ex[2]) begin
            chk("inst", inst, x.ei);
            chk("inst_pc", inst_pc, x.ep);
        end
        {rst, imem_req_ready, imem_resp_valid, imem_resp_err, inst_ready, halt} = x.in;
        imem_resp_data = x.rdata;
        redirect_valid = x.dv;
        redirect_pc    = x.dpc;
        row++;
    endtask

    vec_t tbl [32];

    initial begin
        {rst, imem_req_ready, imem_resp_valid, imem_resp_err, inst_ready, halt} = 6'b100000;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tbl[0]  = mk(6'b100000, 0, 0, 0, 5'b10000, 32'h8000_0000, 0, 0);
        tbl[1]  = mk(6'b010010, 0, 0, 0, 5'b10000, 32'h8000_0000, 0, 0);
        tbl[2]  = mk(6'b010010, 0, 0, 0, 5'b11000, 32'h8000_0000, 0, 0);
        tbl[3]  = mk(6'b011010, 32'h0000_0013, 0, 0, 5'b00000, 0, 0, 0);
        tbl[4]  = mk(6'b010010, 0, 0, 0, 5'b00100, 0, 32'h0000_0013, 32'h8000_0000);
        tbl[5]  = mk(6'b010010, 0, 0, 0, 5'b11000, 32'h8000_0004, 0, 0);
        tbl[6]  = mk(6'b011010, 32'h0010_0093, 0, 0, 5'b00000, 0, 0, 0);
        for (int i = 7; i < 12; i++) tbl[i] = mk(6'b010000, 0, 0, 0, 5'b00100, 0, 32'h0010_0093, 32'h8000_0004);
        tbl[12] = mk(6'b010010, 0, 0, 0, 5'b00100, 0, 32'h0010_0093, 32'h8000_0004);
        tbl[13] = mk(6'b010010, 0, 0, 0, 5'b11000, 32'h8000_0008, 0, 0);
        tbl[14] = mk(6'b010000, 0, 1, 32'h8000_0100, 5'b00000, 0, 0, 0);
        tbl[15] = mk(6'b010000, 0, 0, 0, 5'b00000, 0, 0, 0);
        tbl[16] = mk(6'b011000, 32'hdead_beef, 0, 0, 5'b00000, 0, 0, 0);
        tbl[17] = mk(6'b000000, 0, 1, 32'h8000_0200, 5'b11000, 32'h8000_0100, 0, 0);
        tbl[18] = mk(6'b000000, 0, 0, 0, 5'b11000, 32'h8000_0100, 0, 0);
        tbl[19] = mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0100, 0, 0);
        tbl[20] = mk(6'b011000, 32'h0000_beef, 0, 0, 5'b00000, 0, 0, 0);
        tbl[21] = mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0200, 0, 0);
        tbl[22] = mk(6'b011000, 32'h0020_0113, 0, 0, 5'b00000, 0, 0, 0);
        tbl[23] = mk(6'b010010, 0, 1, 32'h8000_0300, 5'b00100, 0, 32'h0020_0113, 32'h8000_0200);
        tbl[24] = mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0300, 0, 0);
        tbl[25] = mk(6'b011000, 32'h0030_0193, 0, 0, 5'b00000, 0, 0, 0);
        tbl[26] = mk(6'b010010, 0, 0, 0, 5'b00100, 0, 32'h0030_0193, 32'h8000_0300);
        tbl[27] = mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0304, 0, 0);
        tbl[28] = mk(6'b011100, 0, 0, 0, 5'b00000, 0, 0, 0);
        tbl[29] = mk(6'b010000, 0, 1, 32'h8000_0000, 5'b00011, 0, 0, 0);
        tbl[30] = mk(6'b010001, 0, 0, 0, 5'b00011, 0, 0, 0);
        tbl[31] = mk(6'b000000, 0, 0, 0, 5'b00011, 0, 0, 0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) step(tbl[i]);
        // reset clears the fault; redirect in the same cycle as accept, then misaligned redirect
        step(mk(6'b100000, 0, 0, 0, 5'b00011, 0, 0, 0));
        step(mk(6'b010000, 0, 0, 0, 5'b10000, 32'h8000_0000, 0, 0));
        step(mk(6'b010000, 0, 1, 32'h8000_0400, 5'b11000, 32'h8000_0000, 0, 0));
        step(mk(6'b011000, 32'h1111_1111, 0, 0, 5'b00000, 0, 0, 0));
        step(mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0400, 0, 0));
        step(mk(6'b010000, 0, 1, 32'h8000_0102, 5'b00000, 0, 0, 0));
        step(mk(6'b100000, 0, 0, 0, 5'b00011, 0, 0, 0));
        // halt while decode consumes in HOLD
        step(mk(6'b010000, 0, 0, 0, 5'b10000, 32'h8000_0000, 0, 0));
        step(mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0000, 0, 0));
        step(mk(6'b011000, 32'h0000_0013, 0, 0, 5'b00000, 0, 0, 0));
        step(mk(6'b010011, 0, 0, 0, 5'b00100, 0, 32'h0000_0013, 32'h8000_0000));
        step(mk(6'b010000, 0, 0, 0, 5'b00001, 0, 0, 0));
        step(mk(6'b100000, 0, 0, 0, 5'b00001, 0, 0, 0));
        // reset mid-transaction; stale response after release ignored
        step(mk(6'b010000, 0, 0, 0, 5'b10000, 32'h8000_0000, 0, 0));
        step(mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0000, 0, 0));
        step(mk(6'b100000, 0, 0, 0, 5'b00000, 0, 0, 0));
        step(mk(6'b011000, 32'hbad0_bad0, 0, 0, 5'b10000, 32'h8000_0000, 0, 0));
        // two redirects before one response, then PC wrap at the top of the space
        step(mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0000, 0, 0));
        step(mk(6'b010000, 0, 1, 32'hffff_fffc, 5'b00000, 0, 0, 0));
        step(mk(6'b010000, 0, 1, 32'h8000_0010, 5'b00000, 0, 0, 0));
        step(mk(6'b011000, 32'h0000_0022, 0, 0, 5'b00000, 0, 0, 0));
        step(mk(6'b010000, 0, 0, 0, 5'b11000, 32'h8000_0010, 0, 0));
        step(mk(6'b011000, 32'h0000_0033, 0, 0, 5'b00000, 0, 0, 0));
        step(mk(6'b010000, 0, 1, 32'hffff_fffc, 5'b00100, 0, 32'h0000_0033, 32'h8000_0010));
        step(mk(6'b010000, 0, 0, 0, 5'b11000, 32'hffff_fffc, 0, 0));
        step(mk(6'b011000, 32'h0000_0044, 0, 0, 5'b00000, 0, 0, 0));
        step(mk(6'b010010, 0, 0, 0, 5'b00100, 0, 32'h0000_0044, 32'hffff_fffc));
        step(mk(6'b100000, 0, 0, 0, 5'b11000, 32'h0000_0000, 0, 0));
        // halt sampled at IDLE exit
        step(mk(6'b000001, 0, 0, 0, 5'b10000, 32'h8000_0000, 0, 0));
        step(mk(6'b000000, 0, 0, 0, 5'b00001, 0, 0, 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
